// File: rtl/spike_pkg.sv
// Shared constants and event layout for the multi-core spike event collector.
// Unpack evt_dout with the *_LSB offsets or by casting it to evt_t.
package spike_pkg;

  localparam int DEF_CORE_NO     = 4;
  localparam int DEF_NEURON_NO   = 256;
  localparam int DEF_TD_WIDTH    = 16;
  localparam int DEF_FIFO_MEM_NO = 8;
  localparam int DEF_OVF_CNT_LEN = 8;

  function automatic int evt_len(input int core_no, input int neuron_no, input int td_width);
    return $clog2(core_no) + $clog2(neuron_no) + td_width;
  endfunction

  localparam int DEF_CID_LEN = $clog2(DEF_CORE_NO);
  localparam int DEF_NA_LEN  = $clog2(DEF_NEURON_NO);
  localparam int DEF_EVT_LEN = evt_len(DEF_CORE_NO, DEF_NEURON_NO, DEF_TD_WIDTH);

  localparam int TS_LSB  = 0;
  localparam int NA_LSB  = DEF_TD_WIDTH;
  localparam int CID_LSB = DEF_TD_WIDTH + DEF_NA_LEN;

  typedef struct packed {
    logic [DEF_CID_LEN-1:0]  core_id;
    logic [DEF_NA_LEN-1:0]   neuron_addr;
    logic [DEF_TD_WIDTH-1:0] ts;
  } evt_t;

endpackage

// File: rtl/spike_event_collector_if.sv
// Spike inputs, event drain handshake and status of the spike event collector.
// master = collector side, slave = neuron cores plus system controller side.
interface spike_event_collector_if
  import spike_pkg::*;
#(
  parameter int CORE_NO     = DEF_CORE_NO,
  parameter int NEURON_NO   = DEF_NEURON_NO,
  parameter int TD_WIDTH    = DEF_TD_WIDTH,
  parameter int FIFO_MEM_NO = DEF_FIFO_MEM_NO,
  parameter int OVF_CNT_LEN = DEF_OVF_CNT_LEN
);

  localparam int NA_LEN  = $clog2(NEURON_NO);
  localparam int EVT_LEN = evt_len(CORE_NO, NEURON_NO, TD_WIDTH);
  localparam int CNT_LEN = $clog2(FIFO_MEM_NO) + 1;

  logic [CORE_NO-1:0]             spike;
  logic [CORE_NO-1:0][NA_LEN-1:0] spike_addr;
  logic [EVT_LEN-1:0]             evt_dout;
  logic                           evt_valid;
  logic                           evt_rd;
  logic                           full;
  logic                           empty;
  logic [CNT_LEN-1:0]             count;
  logic [OVF_CNT_LEN-1:0]         ovf_cnt;

  modport master (
    input  spike, spike_addr, evt_rd,
    output evt_dout, evt_valid, full, empty, count, ovf_cnt
  );

  modport slave (
    output spike, spike_addr, evt_rd,
    input  evt_dout, evt_valid, full, empty, count, ovf_cnt
  );

endinterface

// File: rtl/evt_fifo.sv
// First-word-fall-through event FIFO with occupancy count and same-cycle push/pop.
// dout is forced to zero while empty so the head never shows stale data.
module evt_fifo
  import spike_pkg::*;
#(
  parameter int WIDTH = DEF_EVT_LEN,
  parameter int DEPTH = DEF_FIFO_MEM_NO
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign count = cnt_q;
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign valid = !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spike_event_collector.sv
// Multi-core spike event collector: per-core capture slots, round-robin arbiter, FWFT event FIFO.
// Define SPIKE_OVF_CNT_EN to build the saturating dropped-spike counter; otherwise ovf_cnt reads 0.
module spike_event_collector
  import spike_pkg::*;
#(
  parameter int CORE_NO     = DEF_CORE_NO,
  parameter int NEURON_NO   = DEF_NEURON_NO,
  parameter int TD_WIDTH    = DEF_TD_WIDTH,
  parameter int FIFO_MEM_NO = DEF_FIFO_MEM_NO,
  parameter int OVF_CNT_LEN = DEF_OVF_CNT_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sys_en,
  input  logic                     tick,
  spike_event_collector_if.master  bus
);

  localparam int CID_LEN = $clog2(CORE_NO);
  localparam int EVT_LEN = evt_len(CORE_NO, NEURON_NO, TD_WIDTH);

  logic [TD_WIDTH-1:0] ts;
  logic [CORE_NO-1:0]  slot_valid;
  logic [EVT_LEN-1:0]  slot_data [CORE_NO];
  logic [CID_LEN-1:0]  rr_ptr;
  logic [CID_LEN-1:0]  cand;
  logic [CID_LEN-1:0]  grant_idx;
  logic                grant_valid;
  logic [CORE_NO-1:0]  grant_hit;
  logic [CORE_NO-1:0]  spike_take;
  logic                push_ok;
  logic                fifo_full;
  logic                fifo_valid;
  logic [EVT_LEN-1:0]  push_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts <= '0;
    end else if (sys_en && tick) begin
      ts <= ts + 1'b1;
    end
  end

  assign push_ok = !fifo_full || (fifo_valid && bus.evt_rd);

  // Search starts at rr_ptr and wraps, so the most recently served core goes last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < CORE_NO; k++) begin
      cand = rr_ptr + CID_LEN'(k);
      if (push_ok && !grant_valid && slot_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= grant_idx + 1'b1;
    end
  end

  // A granted slot is free on this edge, so it may reload from a new spike.
  always_comb begin
    grant_hit  = '0;
    spike_take = '0;
    for (int i = 0; i < CORE_NO; i++) begin
      grant_hit[i]  = grant_valid && (grant_idx == CID_LEN'(i));
      spike_take[i] = bus.spike[i] && sys_en && (!slot_valid[i] || grant_hit[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      for (int i = 0; i < CORE_NO; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CORE_NO; i++) begin
        if (spike_take[i]) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= {CID_LEN'(i), bus.spike_addr[i], ts};
        end else if (grant_hit[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign push_data = slot_data[grant_idx];

  evt_fifo #(
    .WIDTH (EVT_LEN),
    .DEPTH (FIFO_MEM_NO)
  ) u_evt_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant_valid),
    .push_data (push_data),
    .pop       (bus.evt_rd),
    .dout      (bus.evt_dout),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .empty     (bus.empty),
    .count     (bus.count)
  );

  assign bus.evt_valid = fifo_valid;
  assign bus.full      = fifo_full;

`ifdef SPIKE_OVF_CNT_EN
  logic [CID_LEN:0]       drop_num;
  logic [OVF_CNT_LEN:0]   ovf_sum;
  logic [OVF_CNT_LEN-1:0] ovf_q;

  // Several cores can lose a spike on the same edge; each one counts.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < CORE_NO; i++) begin
      if (bus.spike[i] && sys_en && slot_valid[i] && !grant_hit[i]) begin
        drop_num = drop_num + 1'b1;
      end
    end
  end

  assign ovf_sum = {1'b0, ovf_q} + (OVF_CNT_LEN+1)'(drop_num);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_sum[OVF_CNT_LEN] ? '1 : ovf_sum[OVF_CNT_LEN-1:0];
    end
  end

  assign bus.ovf_cnt = ovf_q;
`else
  assign bus.ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_event_collector.sv
// Self-checking bench for spike_event_collector against a queue-based behavioural model.
// Honours SPIKE_OVF_CNT_EN when choosing the expected ovf_cnt.
module tb_spike_event_collector;
  import spike_pkg::*;

  localparam int N       = DEF_CORE_NO;
  localparam int CID_LEN = DEF_CID_LEN;
  localparam int NA_LEN  = DEF_NA_LEN;
  localparam int EVT_LEN = DEF_EVT_LEN;
  localparam int DEPTH   = DEF_FIFO_MEM_NO;
  localparam int TD_MAX  = 2 ** DEF_TD_WIDTH;
  localparam int OVF_MAX = 2 ** DEF_OVF_CNT_LEN - 1;
`ifdef SPIKE_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic sys_en;
  logic tick;

  spike_event_collector_if bus ();

  spike_event_collector dut (
    .clk    (clk),
    .reset  (reset),
    .sys_en (sys_en),
    .tick   (tick),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending slot per core, event queue, timestamp, next core to favour, drops.
  int                 m_ts;
  bit                 m_pv [N];
  logic [EVT_LEN-1:0] m_pd [N];
  int                 m_rr;
  logic [EVT_LEN-1:0] m_q [$];
  int                 m_ovf;

  function automatic logic [EVT_LEN-1:0] mk_evt(input int core, input int addr, input int t);
    evt_t e;
    e.core_id     = CID_LEN'(core);
    e.neuron_addr = NA_LEN'(addr);
    e.ts          = DEF_TD_WIDTH'(t);
    return e;
  endfunction

  task automatic model_reset();
    m_ts  = 0;
    m_rr  = 0;
    m_ovf = 0;
    m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_pv[i] = 1'b0;
      m_pd[i] = '0;
    end
  endtask

  task automatic model_step();
    bit pop;
    bit push_ok;
    int grant;
    pop     = (m_q.size() > 0) && bus.evt_rd;
    push_ok = (m_q.size() < DEPTH) || pop;
    grant   = -1;
    if (push_ok) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (grant < 0 && m_pv[idx]) grant = idx;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (grant >= 0) begin
      m_q.push_back(m_pd[grant]);
      m_pv[grant] = 1'b0;
      m_rr = (grant + 1) % N;
    end
    if (sys_en) begin
      for (int i = 0; i < N; i++) begin
        if (bus.spike[i]) begin
          if (!m_pv[i]) begin
            m_pv[i] = 1'b1;
            m_pd[i] = mk_evt(i, int'(bus.spike_addr[i]), m_ts);
          end else if (m_ovf < OVF_MAX) begin
            m_ovf++;
          end
        end
      end
    end
    if (sys_en && tick) m_ts = (m_ts + 1) % TD_MAX;
  endtask

  function automatic logic [EVT_LEN-1:0] exp_dout();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  function automatic int exp_ovf();
    return OVF_EN ? m_ovf : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle_inputs();
    sys_en = 1'b0;
    tick   = 1'b0;
    bus.spike      = '0;
    bus.spike_addr = '0;
    bus.evt_rd     = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    model_reset();
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", bus.evt_valid); end
    checks++; if (bus.evt_dout !== '0) begin errors++; $display("[TB] FAIL reset_dout got %h expected 0", bus.evt_dout); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b expected 0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b expected 1", bus.empty); end
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", bus.count); end
    checks++; if (bus.ovf_cnt !== '0) begin errors++; $display("[TB] FAIL reset_ovf got %0d expected 0", bus.ovf_cnt); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single_spike();
    logic [EVT_LEN-1:0] want;
    sys_en = 1'b1;
    tick   = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    bus.spike = 4'b0100;
    bus.spike_addr[2] = 8'h3C;
    step();
    bus.spike = '0;
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid got %b expected 0", bus.evt_valid); end
    step();
    want = mk_evt(2, 'h3C, 5);
    checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b expected 1", bus.evt_valid); end
    checks++; if (bus.evt_dout !== want) begin errors++; $display("[TB] FAIL single_dout got %h expected %h", bus.evt_dout, want); end
    bus.evt_rd = 1'b1;
    step();
    bus.evt_rd = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL single_drain_empty got %b expected 1", bus.empty); end
  endtask

  task automatic test_simultaneous();
    int addrs [N];
    logic [EVT_LEN-1:0] want;
    apply_reset();
    sys_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      addrs[i] = int'($urandom_range(0, 255));
      bus.spike_addr[i] = NA_LEN'(addrs[i]);
    end
    bus.spike = '1;
    step();
    bus.spike = '0;
    repeat (4) step();
    checks++; if (bus.count !== 4'd4) begin errors++; $display("[TB] FAIL simul_count got %0d expected 4", bus.count); end
    bus.evt_rd = 1'b1;
    for (int k = 0; k < N; k++) begin
      want = mk_evt(k, addrs[k], 0);
      checks++; if (bus.evt_dout !== want) begin errors++; $display("[TB] FAIL simul_order%0d got %h expected %h", k, bus.evt_dout, want); end
      step();
    end
    bus.evt_rd = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL simul_empty got %b expected 1", bus.empty); end
    checks++; if (bus.ovf_cnt !== '0) begin errors++; $display("[TB] FAIL simul_ovf got %0d expected 0", bus.ovf_cnt); end
  endtask

  task automatic test_fairness();
    evt_t ev;
    int   t3;
    int   core1_before;
    bit   seen3;
    apply_reset();
    sys_en = 1'b1;
    tick   = 1'b1;
    bus.evt_rd = 1'b1;
    t3 = -1;
    core1_before = 0;
    seen3 = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.spike = (cyc == 4) ? 4'b1010 : 4'b0010;
      for (int i = 0; i < N; i++) bus.spike_addr[i] = NA_LEN'($urandom);
      if (cyc == 4) t3 = m_ts;
      step();
      checks++; if (bus.evt_dout !== exp_dout()) begin errors++; $display("[TB] FAIL fair_dout cyc%0d got %h expected %h", cyc, bus.evt_dout, exp_dout()); end
      if (bus.evt_valid) begin
        ev = bus.evt_dout;
        if (ev.core_id == 2'd3) seen3 = 1'b1;
        else if (ev.core_id == 2'd1 && !seen3 && t3 >= 0 && int'(ev.ts) >= t3) core1_before++;
      end
    end
    bus.spike = '0;
    bus.evt_rd = 1'b0;
    tick = 1'b0;
    checks++; if (seen3 !== 1'b1) begin errors++; $display("[TB] FAIL fair_core3_served got %b expected 1", seen3); end
    checks++; if (core1_before > 1) begin errors++; $display("[TB] FAIL fair_grants_before_core3 got %0d expected <=1", core1_before); end
    checks++; if (int'(bus.ovf_cnt) !== exp_ovf()) begin errors++; $display("[TB] FAIL fair_ovf got %0d expected %0d", bus.ovf_cnt, exp_ovf()); end
  endtask

  task automatic test_overflow_and_full_pop();
    int addrs [12];
    logic [EVT_LEN-1:0] want;
    apply_reset();
    sys_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      addrs[k] = int'($urandom_range(0, 255));
      bus.spike = 4'b0001;
      bus.spike_addr[0] = NA_LEN'(addrs[k]);
      step();
    end
    bus.spike = '0;
    checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %b expected 1", bus.full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL ovf_count got %0d expected 8", bus.count); end
    checks++; if (int'(bus.ovf_cnt) !== (OVF_EN ? 3 : 0)) begin errors++; $display("[TB] FAIL ovf_cnt got %0d expected %0d", bus.ovf_cnt, OVF_EN ? 3 : 0); end
    want = mk_evt(0, addrs[0], 0);
    checks++; if (bus.evt_dout !== want) begin errors++; $display("[TB] FAIL ovf_head got %h expected %h", bus.evt_dout, want); end
    bus.evt_rd = 1'b1;
    step();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL fullpop_count got %0d expected 8", bus.count); end
    for (int k = 1; k <= 8; k++) begin
      want = mk_evt(0, addrs[k], 0);
      checks++; if (bus.evt_dout !== want) begin errors++; $display("[TB] FAIL fullpop_drain%0d got %h expected %h", k, bus.evt_dout, want); end
      step();
    end
    bus.evt_rd = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_empty got %b expected 1", bus.empty); end
  endtask

  task automatic test_sys_en_off();
    int ovf_before;
    ovf_before = int'(bus.ovf_cnt);
    sys_en = 1'b0;
    tick   = 1'b1;
    bus.spike = '1;
    repeat (3) step();
    bus.spike = '0;
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL en_off_count got %0d expected 0", bus.count); end
    checks++; if (int'(bus.ovf_cnt) !== ovf_before) begin errors++; $display("[TB] FAIL en_off_ovf got %0d expected %0d", bus.ovf_cnt, ovf_before); end
    sys_en = 1'b1;
    tick   = 1'b0;
    bus.spike = 4'b0001;
    bus.spike_addr[0] = 8'h11;
    step();
    bus.spike = '0;
    step();
    checks++; if (bus.evt_dout !== exp_dout()) begin errors++; $display("[TB] FAIL en_off_ts got %h expected %h", bus.evt_dout, exp_dout()); end
    bus.evt_rd = 1'b1;
    step();
    bus.evt_rd = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    logic [EVT_LEN-1:0] want;
    apply_reset();
    sys_en = 1'b1;
    tick   = 1'b1;
    repeat (TD_MAX - 1) step();
    bus.spike = 4'b0001;
    bus.spike_addr[0] = 8'hA5;
    step();
    bus.spike = 4'b0010;
    bus.spike_addr[1] = 8'h5A;
    step();
    bus.spike = '0;
    tick = 1'b0;
    step();
    step();
    want = mk_evt(0, 'hA5, TD_MAX - 1);
    checks++; if (bus.evt_dout !== want) begin errors++; $display("[TB] FAIL wrap_last_ts got %h expected %h", bus.evt_dout, want); end
    checks++; if (bus.count !== 4'd2) begin errors++; $display("[TB] FAIL wrap_count got %0d expected 2", bus.count); end
    bus.evt_rd = 1'b1;
    step();
    bus.evt_rd = 1'b0;
    want = mk_evt(1, 'h5A, 0);
    checks++; if (bus.evt_dout !== want) begin errors++; $display("[TB] FAIL wrap_zero_ts got %h expected %h", bus.evt_dout, want); end
    for (int c = 0; c < 6; c++) begin
      bus.spike = N'($urandom);
      for (int i = 0; i < N; i++) bus.spike_addr[i] = NA_LEN'($urandom);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got %b expected 0", bus.evt_valid); end
    checks++; if (bus.evt_dout !== '0) begin errors++; $display("[TB] FAIL midreset_dout got %h expected 0", bus.evt_dout); end
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL midreset_count got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags got empty=%b full=%b expected empty=1 full=0", bus.empty, bus.full); end
    checks++; if (bus.ovf_cnt !== '0) begin errors++; $display("[TB] FAIL midreset_ovf got %0d expected 0", bus.ovf_cnt); end
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      sys_en = ($urandom_range(0, 9) != 0);
      tick   = $urandom_range(0, 1);
      bus.spike = N'($urandom);
      for (int i = 0; i < N; i++) bus.spike_addr[i] = NA_LEN'($urandom);
      bus.evt_rd = (c < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
      checks++; if (bus.evt_valid !== (m_q.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid c%0d got %b expected %b", c, bus.evt_valid, m_q.size() > 0); end
      checks++; if (bus.evt_dout !== exp_dout()) begin errors++; $display("[TB] FAIL rand_dout c%0d got %h expected %h", c, bus.evt_dout, exp_dout()); end
      checks++; if (int'(bus.count) !== m_q.size()) begin errors++; $display("[TB] FAIL rand_count c%0d got %0d expected %0d", c, bus.count, m_q.size()); end
      checks++; if (bus.full !== (m_q.size() == DEPTH)) begin errors++; $display("[TB] FAIL rand_full c%0d got %b expected %b", c, bus.full, m_q.size() == DEPTH); end
      checks++; if (bus.empty !== (m_q.size() == 0)) begin errors++; $display("[TB] FAIL rand_empty c%0d got %b expected %b", c, bus.empty, m_q.size() == 0); end
      checks++; if (int'(bus.ovf_cnt) !== exp_ovf()) begin errors++; $display("[TB] FAIL rand_ovf c%0d got %0d expected %0d", c, bus.ovf_cnt, exp_ovf()); end
    end
    idle_inputs();
  endtask

  initial begin
    $display("[TB] starting spike_event_collector bench");
    test_reset();
    test_single_spike();
    test_simultaneous();
    test_fairness();
    test_overflow_and_full_pop();
    test_sys_en_off();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
